multi_port_mem_arbiter: RTL and testbench
=========================================

MULTI_PORT_MEM_ARBITER -- requirements
Module: multi_port_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 16, memory data width in bits.
REQ-003 Parameter N_PORTS, default 3, number of requesters; legal range 2..8.
REQ-004 Parameter MEM_LATENCY, default 1, cycles from read command to valid mem_value_i; legal range 1..4.
REQ-005 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  asynchronous, active-low reset.
REQ-007 req_i  input  N_PORTS  per-port request, level, held until that port's gnt_o.
REQ-008 we_i  input  N_PORTS  per-port write (1) / read (0) select, qualified by req_i.
REQ-009 addr_i  input  N_PORTS*ADDR_WIDTH  per-port address; port p at slice [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 wdata_i  input  N_PORTS*DATA_WIDTH  per-port write data; port p at slice [p*DATA_WIDTH +: DATA_WIDTH].
REQ-011 gnt_o  output  N_PORTS  one-hot, one-cycle pulse: port's command is on the memory bus.
REQ-012 rvalid_o  output  N_PORTS  one-hot, one-cycle pulse: rdata_o holds the port's read data.
REQ-013 rdata_o  output  DATA_WIDTH  read data, valid only with an rvalid_o bit.
REQ-014 busy_o  output  1  high in every state except IDLE.
REQ-015 mem_value_i  input  DATA_WIDTH  memory read data.
REQ-016 mem_addr_o  output  ADDR_WIDTH  memory address.
REQ-017 mem_value_o  output  DATA_WIDTH  memory write data.
REQ-018 mem_rd_en_o / mem_wr_en_o  output  1 each  memory read / write strobe.
REQ-019 mem_enable_o  output  1  equals mem_rd_en_o OR mem_wr_en_o.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; all outputs SHALL be registered, except mem_enable_o, which is combinational.
REQ-021 IDLE with any req_i bit high SHALL select one port p, latch its we/addr/wdata, and enter ISSUE next cycle; with no request, SHALL stay in IDLE.
REQ-022 ISSUE (exactly one cycle) SHALL drive gnt_o[p]=1, mem_addr_o=addr(p), and exactly one strobe: mem_wr_en_o=we(p), mem_rd_en_o=!we(p); mem_value_o=wdata(p) on writes.
REQ-023 ISSUE with a write SHALL go to IDLE; ISSUE with a read SHALL go to WAIT.
REQ-024 WAIT SHALL last exactly MEM_LATENCY cycles, sample mem_value_i at the end of the last WAIT cycle, then enter RESP.
REQ-025 RESP (one cycle) SHALL drive rvalid_o[p]=1 with rdata_o=sampled data, and SHALL arbitrate like IDLE: go to ISSUE if any req_i is high, else to IDLE.
REQ-026 Read latency SHALL be: request seen in cycle 0, gnt_o in cycle 1, rvalid_o in cycle 2+MEM_LATENCY.
REQ-027 Outside ISSUE, gnt_o, mem_rd_en_o and mem_wr_en_o SHALL be 0; outside RESP, rvalid_o SHALL be 0; mem_addr_o, mem_value_o and rdata_o SHALL hold their last values.
REQ-028 Inputs of non-selected ports SHALL be ignored; req_i changes after selection SHALL NOT affect the transaction in flight.
REQ-029 A port's request sampled while its own transaction is in flight SHALL be treated as a new request.
REQ-030 we_i, addr_i and wdata_i SHALL be ignored for ports whose req_i is low.

Reset
REQ-031 On rst_i low, without waiting for a clock: state=IDLE; gnt_o, rvalid_o, mem_rd_en_o, mem_wr_en_o, mem_enable_o, busy_o = 0; mem_addr_o, mem_value_o, rdata_o = 0; round-robin pointer=N_PORTS-1.
REQ-032 Reset asserted during ISSUE, WAIT or RESP SHALL abort the transaction; rvalid_o SHALL NOT be emitted for it after reset release.
REQ-033 The first arbitration after reset release SHALL occur on the first rising edge with rst_i high.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: the winner SHALL be the first requesting port at or after (last granted port + 1) mod N_PORTS, searching upward with wrap-around; the pointer SHALL update only on entry to ISSUE.
REQ-035 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority; the lowest requesting index SHALL win; the pointer logic SHALL be absent.

Verification
REQ-036 Write test: port 1 write addr 0x12 data 0xBEEF, N_PORTS=3 -> gnt_o=3'b010 and mem_wr_en_o=1 with mem_addr_o=0x12, mem_value_o=0xBEEF in cycle 1; busy_o=0 in cycle 2.
REQ-037 Read test: port 0 reads addr 0x05, MEM_LATENCY=2, memory returns 0x1234 -> gnt_o[0]=1 in cycle 1, rvalid_o=3'b001 with rdata_o=0x1234 in cycle 4, single pulse.
REQ-038 Round-robin test (macro defined): req_i=3'b111 held, all writes -> grant order port 0,1,2,0 on ISSUE cycles 1,3,5,7.
REQ-039 Fixed-priority test (macro undefined): same stimulus -> every grant goes to port 0.
REQ-040 Reset test: rst_i pulsed low during WAIT of a read -> all outputs 0 immediately; no rvalid_o after release; next request gets gnt_o one cycle after sampling.

Source files
------------

// File: rtl/multi_port_mem_arbiter.sv
// rtl/multi_port_mem_arbiter.sv - N-port requester arbiter sharing one memory bus
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module multi_port_mem_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int N_PORTS     = 3,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_PORTS-1:0]            req_i,
  input  logic [N_PORTS-1:0]            we_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [N_PORTS-1:0]            gnt_o,
  output logic [N_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          busy_o,
  input  logic [DATA_WIDTH-1:0]         mem_value_i,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_value_o,
  output logic                          mem_rd_en_o,
  output logic                          mem_wr_en_o,
  output logic                          mem_enable_o
);
  localparam int PW = $clog2(N_PORTS);
  localparam int CW = 2;
  localparam logic [N_PORTS-1:0] ONE = N_PORTS'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_port;
  logic [CW-1:0]         r_cnt;
  logic [N_PORTS-1:0]    r_gnt;
  logic [N_PORTS-1:0]    r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_busy;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_value;
  logic                  r_rd;
  logic                  r_wr;

  logic [PW-1:0]         w_sel;
  logic                  w_any;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_any   = |req_i;
  assign w_we    = we_i[w_sel];
  assign w_addr  = addr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wdata = wdata_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];

`ifdef ARB_ROUND_ROBIN_EN
  logic [PW-1:0] r_ptr;

  // Scan from farthest to nearest so the port closest after r_ptr is assigned last.
  always_comb begin
    w_sel = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      if (req_i[(int'(r_ptr) + k) % N_PORTS]) w_sel = PW'((int'(r_ptr) + k) % N_PORTS);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_ptr <= PW'(N_PORTS - 1);
    else if ((r_state == S_IDLE || r_state == S_RESP) && w_any) r_ptr <= w_sel;
  end
`else
  always_comb begin
    w_sel = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req_i[i]) w_sel = PW'(i);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_port   <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_value  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_any) begin
            r_port  <= w_sel;
            r_gnt   <= ONE << w_sel;
            r_addr  <= w_addr;
            r_wr    <= w_we;
            r_rd    <= !w_we;
            if (w_we) r_value <= w_wdata;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        // r_wr still reflects the issued command's direction during ISSUE.
        S_ISSUE: begin
          if (r_wr) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= CW'(MEM_LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_busy <= 1'b1;
          if (r_cnt == '0) begin
            r_rdata  <= mem_value_i;
            r_rvalid <= ONE << r_port;
            r_state  <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o        = r_gnt;
  assign rvalid_o     = r_rvalid;
  assign rdata_o      = r_rdata;
  assign busy_o       = r_busy;
  assign mem_addr_o   = r_addr;
  assign mem_value_o  = r_value;
  assign mem_rd_en_o  = r_rd;
  assign mem_wr_en_o  = r_wr;
  assign mem_enable_o = r_rd | r_wr;

endmodule

// File: tb/tb_multi_port_mem_arbiter.sv
// tb/tb_multi_port_mem_arbiter.sv - vector table, corner sequences and random traffic vs transaction model
module tb_multi_port_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int L  = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i, we_i;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o, mem_value_i, mem_value_o;
  logic            busy_o, mem_rd_en_o, mem_wr_en_o, mem_enable_o;
  logic [AW-1:0]   mem_addr_o;

  multi_port_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_PORTS(N), .MEM_LATENCY(L)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .mem_value_i(mem_value_i), .mem_addr_o(mem_addr_o), .mem_value_o(mem_value_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_enable_o(mem_enable_o));

  always #5 clk_i = ~clk_i;

  // Memory slave: read data appears L cycles after the read strobe, noise otherwise.
  logic [DW-1:0] smem [256];
  logic [DW-1:0] pipe [L];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  always @(posedge clk_i) begin
    if (ld_en) smem[ld_addr] <= ld_data;
    else if (mem_wr_en_o) smem[mem_addr_o] <= mem_value_o;
    pipe[0] <= mem_rd_en_o ? smem[mem_addr_o] : DW'($urandom);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_value_i = pipe[L-1];

  logic [DW-1:0] mmem [256];
  int total = 0;
  int bad   = 0;

  typedef struct {
    int port; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    logic pre; logic [DW-1:0] memval;
    logic [N-1:0] egnt; logic [N-1:0] ervalid; logic [DW-1:0] erdata;
  } vec_t;

  typedef struct {
    logic [N-1:0] gnt; logic [N-1:0] rvalid; logic rd; logic wr; logic busy;
    logic ua; logic [AW-1:0] a; logic uv; logic [DW-1:0] v; logic ur; logic [DW-1:0] r;
  } ev_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tg, input logic [N-1:0] g, input logic [N-1:0] rv, input logic rd,
                         input logic wr, input logic bz, input logic [AW-1:0] a, input logic [DW-1:0] v,
                         input logic [DW-1:0] r);
    chk({tg, ".gnt"},    32'(gnt_o),        32'(g));
    chk({tg, ".rvalid"}, 32'(rvalid_o),     32'(rv));
    chk({tg, ".rd_en"},  32'(mem_rd_en_o),  32'(rd));
    chk({tg, ".wr_en"},  32'(mem_wr_en_o),  32'(wr));
    chk({tg, ".enable"}, 32'(mem_enable_o), 32'(rd | wr));
    chk({tg, ".busy"},   32'(busy_o),       32'(bz));
    chk({tg, ".addr"},   32'(mem_addr_o),   32'(a));
    chk({tg, ".wvalue"}, 32'(mem_value_o),  32'(v));
    chk({tg, ".rdata"},  32'(rdata_o),      32'(r));
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d; mmem[a] = d;
    @(negedge clk_i);
    ld_en = 1'b0;
  endtask

  task automatic idle_all();
    req_i   = '0;
    we_i    = N'($urandom);
    addr_i  = (N*AW)'($urandom);
    wdata_i = (N*DW)'({$urandom, $urandom});
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_i[p] = r; we_i[p] = w; addr_i[p*AW +: AW] = a; wdata_i[p*DW +: DW] = d;
  endtask

  // Winner: first requester scanning upward from last+1 with wrap; fixed priority uses last = N-1.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  vec_t tbl [7];
  ev_t  ring [16];
  int   order [4];

  initial begin
    tbl[0] = '{1, 1'b1, 8'h12, 16'hBEEF, 1'b0, 16'h0000, 3'b010, 3'b000, 16'h0000};
    tbl[1] = '{0, 1'b0, 8'h05, 16'h0000, 1'b1, 16'h1234, 3'b001, 3'b001, 16'h1234};
    tbl[2] = '{2, 1'b0, 8'hFF, 16'h0000, 1'b1, 16'hA5A5, 3'b100, 3'b100, 16'hA5A5};
    tbl[3] = '{2, 1'b1, 8'h00, 16'h0001, 1'b0, 16'h0000, 3'b100, 3'b000, 16'h0000};
    tbl[4] = '{0, 1'b1, 8'h40, 16'h4321, 1'b0, 16'h0000, 3'b001, 3'b000, 16'h0000};
    tbl[5] = '{1, 1'b0, 8'h40, 16'h0000, 1'b0, 16'h0000, 3'b010, 3'b010, 16'h4321};
    tbl[6] = '{1, 1'b0, 8'h12, 16'h0000, 1'b0, 16'h0000, 3'b010, 3'b010, 16'hBEEF};
`ifdef ARB_ROUND_ROBIN_EN
    order = '{0, 1, 2, 0};
`else
    order = '{0, 0, 0, 0};
`endif

    rst_i = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    idle_all();
    @(negedge clk_i);
    for (int a = 0; a < 256; a++) preload(AW'(a), DW'($urandom));
    chk_all("reset", '0, '0, 0, 0, 0, '0, '0, '0);

    // All ports request writes continuously from the first cycle after reset release.
    rst_i = 1'b1;
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b1, AW'(8'h20 + p), DW'(16'hA000 + p));
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_i);
      if (c % 2 == 1) begin
        chk($sformatf("arb.gnt_c%0d", c), 32'(gnt_o), 32'(1 << order[(c-1)/2]));
        chk($sformatf("arb.wr_c%0d", c), 32'(mem_wr_en_o), 32'(1));
        mmem[8'h20 + order[(c-1)/2]] = DW'(16'hA000 + order[(c-1)/2]);
      end else begin
        chk($sformatf("arb.gnt_c%0d", c), 32'(gnt_o), 32'(0));
      end
    end
    idle_all();
    @(negedge clk_i);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].pre) preload(tbl[i].addr, tbl[i].memval);
      idle_all();
      set_port(tbl[i].port, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].we) mmem[tbl[i].addr] = tbl[i].wdata;
      @(negedge clk_i);
      chk($sformatf("v%0d.gnt", i),  32'(gnt_o),       32'(tbl[i].egnt));
      chk($sformatf("v%0d.addr", i), 32'(mem_addr_o),  32'(tbl[i].addr));
      chk($sformatf("v%0d.wr", i),   32'(mem_wr_en_o), 32'(tbl[i].we));
      chk($sformatf("v%0d.rd", i),   32'(mem_rd_en_o), 32'(!tbl[i].we));
      chk($sformatf("v%0d.busy", i), 32'(busy_o),      32'(1));
      if (tbl[i].we) chk($sformatf("v%0d.wvalue", i), 32'(mem_value_o), 32'(tbl[i].wdata));
      idle_all();
      if (tbl[i].we) begin
        @(negedge clk_i);
        chk($sformatf("v%0d.busy_after", i), 32'(busy_o), 32'(0));
        chk($sformatf("v%0d.gnt_after", i),  32'(gnt_o),  32'(0));
      end else begin
        for (int w = 0; w < L; w++) begin
          @(negedge clk_i);
          chk($sformatf("v%0d.rvalid_early%0d", i, w), 32'(rvalid_o), 32'(0));
        end
        @(negedge clk_i);
        chk($sformatf("v%0d.rvalid", i), 32'(rvalid_o), 32'(tbl[i].ervalid));
        chk($sformatf("v%0d.rdata", i),  32'(rdata_o),  32'(tbl[i].erdata));
        @(negedge clk_i);
        chk($sformatf("v%0d.rvalid_late", i), 32'(rvalid_o), 32'(0));
        chk($sformatf("v%0d.busy_late", i),   32'(busy_o),   32'(0));
      end
    end

    // Reset pulsed while a read is waiting on memory.
    preload(8'h30, 16'h5A5A);
    idle_all();
    set_port(0, 1'b1, 1'b0, 8'h30, 16'h0);
    @(negedge clk_i);
    idle_all();
    @(negedge clk_i);
    chk("rstwait.busy_before", 32'(busy_o), 32'(1));
    #2 rst_i = 1'b0;
    #1 chk_all("rst_async", '0, '0, 0, 0, 0, '0, '0, '0);
    @(negedge clk_i);
    set_port(2, 1'b1, 1'b1, 8'h31, 16'h7777);
    mmem[8'h31] = 16'h7777;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_rel.gnt",    32'(gnt_o),    32'(3'b100));
    chk("rst_rel.rvalid", 32'(rvalid_o), 32'(0));
    idle_all();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      chk($sformatf("rst_rel.no_rvalid%0d", c), 32'(rvalid_o), 32'(0));
    end

    // Random traffic against a transaction-level timeline model.
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    begin
      logic [N-1:0]  pend, pwe, reqv;
      logic [AW-1:0] paddr [N];
      logic [DW-1:0] pdata [N];
      logic [AW-1:0] cur_a;
      logic [DW-1:0] cur_v, cur_r;
      int next_arb, last, w, s;
      ev_t e;
      pend = '0; pwe = '0; cur_a = '0; cur_v = '0; cur_r = '0;
      next_arb = 0; last = N - 1;
      for (int p = 0; p < N; p++) begin paddr[p] = '0; pdata[p] = '0; end
      for (int i = 0; i < 16; i++) ring[i] = '{default: '0};
      for (int t = 0; t < 600; t++) begin
        e = ring[t % 16];
        if (e.ua) cur_a = e.a;
        if (e.uv) cur_v = e.v;
        if (e.ur) cur_r = e.r;
        chk_all($sformatf("rnd%0d", t), e.gnt, e.rvalid, e.rd, e.wr, e.busy, cur_a, cur_v, cur_r);
        for (int p = 0; p < N; p++) begin
          if (e.gnt[p]) pend[p] = 1'b0;
          if (!pend[p] && $urandom_range(0, 2) == 0) begin
            pend[p] = 1'b1; pwe[p] = 1'($urandom);
            paddr[p] = AW'($urandom_range(0, 15)); pdata[p] = DW'($urandom);
          end
          if (pend[p]) set_port(p, 1'b1, pwe[p], paddr[p], pdata[p]);
          else set_port(p, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
        end
        reqv = pend;
        if (t == next_arb) begin
          if (reqv != '0) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = pick(reqv, last);
            last = w;
`else
            w = pick(reqv, N - 1);
`endif
            s = (t + 1) % 16;
            ring[s].gnt = N'(1 << w); ring[s].ua = 1'b1; ring[s].a = paddr[w]; ring[s].busy = 1'b1;
            if (pwe[w]) begin
              ring[s].wr = 1'b1; ring[s].uv = 1'b1; ring[s].v = pdata[w];
              mmem[paddr[w]] = pdata[w];
              next_arb = t + 2;
            end else begin
              ring[s].rd = 1'b1;
              for (int k = 2; k <= L + 2; k++) ring[(t + k) % 16].busy = 1'b1;
              s = (t + L + 2) % 16;
              ring[s].rvalid = N'(1 << w); ring[s].ur = 1'b1; ring[s].r = mmem[paddr[w]];
              next_arb = t + L + 2;
            end
          end else begin
            next_arb = t + 1;
          end
        end
        ring[t % 16] = '{default: '0};
        @(negedge clk_i);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
